// File: rtl/image_stream_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : image_stream_framer_if
//  Description : Control, upstream pixel stream and downstream protocol byte
//                stream of the image stream framer, bundled as one interface.
//                master = framer side, slave = surrounding logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface image_stream_framer_if #(
    parameter int DATA_BITS_OUT = 8
);
    // Frame request
    logic                     start;
    logic [15:0]              width_in;
    logic [15:0]              height_in;
    logic [1:0]               pattern_sel;

    // Upstream pixel stream
    logic [DATA_BITS_OUT-1:0] data_in;
    logic                     valid_in;
    logic                     ready_in;

    // Downstream protocol byte stream
    logic [DATA_BITS_OUT-1:0] data_out;
    logic                     valid_out;
    logic                     ready_out;

    // Status
    logic                     busy;
    logic                     done;
    logic                     dim_err;

    modport master (
        input  start,
        input  width_in,
        input  height_in,
        input  pattern_sel,
        input  data_in,
        input  valid_in,
        output ready_in,
        output data_out,
        output valid_out,
        input  ready_out,
        output busy,
        output done,
        output dim_err
    );

    modport slave (
        output start,
        output width_in,
        output height_in,
        output pattern_sel,
        output data_in,
        output valid_in,
        input  ready_in,
        input  data_out,
        input  valid_out,
        output ready_out,
        input  busy,
        input  done,
        input  dim_err
    );
endinterface : image_stream_framer_if
`default_nettype wire

// File: rtl/image_stream_framer.sv
`default_nettype none
// ============================================================================
//  Module      : image_stream_framer
//  Description : Transmit side of the Sobel byte-stream protocol. Emits a
//                4-byte little-endian header (width, height) followed by
//                width*height raster-order pixels taken from an upstream
//                valid/ready stream or an internal test pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module image_stream_framer #(
    parameter int DATA_BITS_OUT = 8,
    parameter int MAX_WIDTH     = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    image_stream_framer_if.master bus
);

    localparam logic [15:0] c_max_width = 16'(MAX_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [15:0]              r_width;
    logic [15:0]              r_height;
    logic [1:0]               r_pattern;
    logic [15:0]              r_x;
    logic [15:0]              r_y;
    logic [1:0]               r_hdr_cnt;
    logic                     r_last_loaded;
    logic [DATA_BITS_OUT-1:0] r_data_out;
    logic                     r_valid_out;
    logic                     r_dim_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    state_t                   w_state_nxt;
    logic                     w_can_load;
    logic                     w_dims_ok;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_load;
    logic [DATA_BITS_OUT-1:0] w_load_byte;
    logic                     w_ready_in;
    logic                     w_pix_adv;
    logic                     w_x_last;
    logic                     w_y_last;
    logic                     w_last_pix;
    logic                     w_xfer;
    logic [DATA_BITS_OUT-1:0] w_hdr_byte;
    logic [DATA_BITS_OUT-1:0] w_pat_byte;

    // The output register can take a new byte when empty or draining this cycle.
    assign w_can_load = !r_valid_out || bus.ready_out;
    assign w_xfer     = r_valid_out && bus.ready_out;

    // Zero-sized or over-wide frames are refused before any byte is sent.
    assign w_dims_ok  = (bus.width_in != 16'd0) && (bus.height_in != 16'd0) &&
                        (bus.width_in <= c_max_width);

    // Frame end is found by coordinate compare, so no width*height product.
    assign w_x_last   = (r_x == (r_width  - 16'd1));
    assign w_y_last   = (r_y == (r_height - 16'd1));
    assign w_last_pix = w_x_last && w_y_last;

    // Header byte selected by the header counter, little-endian order.
    always_comb begin
        w_hdr_byte = '0;
        case (r_hdr_cnt)
            2'd0:    w_hdr_byte = DATA_BITS_OUT'(r_width[7:0]);
            2'd1:    w_hdr_byte = DATA_BITS_OUT'(r_width[15:8]);
            2'd2:    w_hdr_byte = DATA_BITS_OUT'(r_height[7:0]);
            default: w_hdr_byte = DATA_BITS_OUT'(r_height[15:8]);
        endcase
    end

    // Test pattern pixel for the current coordinate.
    always_comb begin
        w_pat_byte = '0;
        case (r_pattern)
            2'd1:    w_pat_byte = DATA_BITS_OUT'(r_x[7:0]);
            2'd2:    w_pat_byte = DATA_BITS_OUT'(r_y[7:0]);
            2'd3:    w_pat_byte = DATA_BITS_OUT'({8{r_x[3] ^ r_y[3]}});
            default: w_pat_byte = '0;
        endcase
    end

    // Next-state and load decisions; the first header byte is loaded on accept
    // so it appears the cycle after start.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_load_byte = '0;
        w_ready_in  = 1'b0;
        w_pix_adv   = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
                if (bus.start) begin
                    if (w_dims_ok) begin
                        w_accept    = 1'b1;
                        w_load      = 1'b1;
                        w_load_byte = DATA_BITS_OUT'(bus.width_in[7:0]);
                        w_state_nxt = ST_HDR;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_load_byte = w_hdr_byte;
                    if (r_hdr_cnt == 2'd3) begin
                        w_state_nxt = ST_PIX;
                    end
                end
            end

            ST_PIX: begin
                if (!r_last_loaded && w_can_load) begin
                    if (r_pattern == 2'd0) begin
                        w_ready_in = 1'b1;
                        if (bus.valid_in) begin
                            w_load      = 1'b1;
                            w_load_byte = bus.data_in;
                            w_pix_adv   = 1'b1;
                        end
                    end else begin
                        w_load      = 1'b1;
                        w_load_byte = w_pat_byte;
                        w_pix_adv   = 1'b1;
                    end
                end
                if (r_last_loaded && w_xfer) begin
                    w_state_nxt = ST_DONE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One-deep output register; holds its byte while the receiver stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else if (w_load) begin
            r_data_out  <= w_load_byte;
            r_valid_out <= 1'b1;
        end else if (w_xfer) begin
            r_valid_out <= 1'b0;
        end
    end

    // Frame configuration, header counter and raster coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width       <= '0;
            r_height      <= '0;
            r_pattern     <= '0;
            r_hdr_cnt     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_last_loaded <= 1'b0;
        end else if (w_accept) begin
            r_width       <= bus.width_in;
            r_height      <= bus.height_in;
            r_pattern     <= bus.pattern_sel;
            r_hdr_cnt     <= 2'd1;
            r_x           <= '0;
            r_y           <= '0;
            r_last_loaded <= 1'b0;
        end else begin
            if ((r_state == ST_HDR) && w_load) begin
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
            end
            if (w_pix_adv) begin
                r_last_loaded <= w_last_pix;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
        end
    end

    // Reject pulse lasts exactly one cycle after the refused start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dim_err <= 1'b0;
        end else begin
            r_dim_err <= w_reject;
        end
    end

    assign bus.ready_in  = w_ready_in;
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.busy      = (r_state == ST_HDR) || (r_state == ST_PIX);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.dim_err   = r_dim_err;

endmodule : image_stream_framer
`default_nettype wire

// File: tb/tb_image_stream_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_stream_framer
//  Description : Self-checking bench for image_stream_framer. Received bytes
//                are compared with a frame built from width/height/pattern
//                rules and the upstream pixel list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_stream_framer;

    localparam int c_max_width = 2048;

    logic clk;
    logic rst;

    image_stream_framer_if #(.DATA_BITS_OUT(8)) bus ();

    image_stream_framer #(
        .DATA_BITS_OUT (8),
        .MAX_WIDTH     (c_max_width)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_err;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] src_q[$];
    int         next_w;
    int         next_h;
    int         next_pat;

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, then every pixel in raster order.
    task automatic build_expected(input int w, input int h, input int pat);
        exp_q.delete();
        exp_q.push_back(8'(w));
        exp_q.push_back(8'(w >> 8));
        exp_q.push_back(8'(h));
        exp_q.push_back(8'(h >> 8));
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                case (pat)
                    0:       exp_q.push_back(src_q[y * w + x]);
                    1:       exp_q.push_back(8'(x % 256));
                    2:       exp_q.push_back(8'(y % 256));
                    default: exp_q.push_back((((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00);
                endcase
            end
        end
    endtask

    // Drive one frame and observe it. rdy_mode: 0 high, 1 toggling, 2 random.
    // vld_mode: 0 high, 1 every other cycle, 2 random.
    task automatic run_frame(input int w, input int h, input int pat, input int rdy_mode,
                             input int vld_mode, input bit skip_start, input bit chain,
                             input int mid_start_at, input int abort_at);
        int         cyc, first_v, first_x, last_x, done_cyc, ups, src_idx, budget;
        bit         done_seen, aborted, last_seen, rin_early, rin_pat, dim_seen, hold_v;
        logic [7:0] hold_b;
        build_expected(w, h, pat);
        rx_q.delete();
        first_v = -1; first_x = -1; last_x = -1; done_cyc = -1; ups = 0; src_idx = 0;
        done_seen = 0; aborted = 0; last_seen = 0; rin_early = 0; rin_pat = 0;
        dim_seen = 0; hold_v = 0; hold_b = '0;
        budget = 8 * (w * h + 4) + 40;
        cyc = skip_start ? 1 : 0;
        while (!done_seen && !aborted && cyc < budget) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (cyc == 0) begin
                bus.start = 1'b1; bus.width_in = 16'(w); bus.height_in = 16'(h);
                bus.pattern_sel = 2'(pat);
            end
            if (cyc == mid_start_at) begin
                bus.start = 1'b1; bus.width_in = 16'd5; bus.height_in = 16'd3;
                bus.pattern_sel = 2'd1;
            end
            if (chain && last_seen) begin
                bus.start = 1'b1; bus.width_in = 16'(next_w); bus.height_in = 16'(next_h);
                bus.pattern_sel = 2'(next_pat);
            end
            rst = (cyc == abort_at);
            case (rdy_mode)
                0:       bus.ready_out = 1'b1;
                1:       bus.ready_out = cyc[0];
                default: bus.ready_out = ($urandom_range(99, 0) < 60);
            endcase
            case (vld_mode)
                0:       bus.valid_in = 1'b1;
                1:       bus.valid_in = (cyc % 2 == 0);
                default: bus.valid_in = ($urandom_range(99, 0) < 50);
            endcase
            bus.data_in = (src_idx < src_q.size()) ? src_q[src_idx] : 8'($urandom);

            @(negedge clk);
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk("abort_valid_out", 32'(bus.valid_out), 0);
                chk("abort_busy", 32'(bus.busy), 0);
                chk("abort_ready_in", 32'(bus.ready_in), 0);
                chk("abort_done", 32'(bus.done), 0);
                aborted = 1;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", 32'(bus.valid_out), 1);
                    chk("hold_data", 32'(bus.data_out), 32'(hold_b));
                end
                hold_v = bus.valid_out && !bus.ready_out;
                hold_b = bus.data_out;
                if (bus.valid_out && first_v < 0) first_v = cyc;
                if (bus.valid_out && bus.ready_out) begin
                    rx_q.push_back(bus.data_out);
                    if (first_x < 0) first_x = cyc;
                    last_x = cyc;
                    if (rx_q.size() == exp_q.size()) last_seen = 1;
                end
                if (bus.valid_in && bus.ready_in) begin
                    ups++;
                    src_idx++;
                end
                if (bus.ready_in && cyc <= 3) rin_early = 1;
                if (bus.ready_in && pat != 0) rin_pat = 1;
                if (bus.dim_err) dim_seen = 1;
                if (cyc == 1) chk("busy_after_start", 32'(bus.busy), 1);
                if (bus.done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                    chk("done_busy", 32'(bus.busy), 0);
                    chk("done_valid_out", 32'(bus.valid_out), 0);
                end
            end
            cyc++;
        end
        rst = 1'b0;
        if (aborted) return;

        chk("done_timeout", 32'(done_seen), 1);
        chk("byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("byte[%0d]", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        chk("first_valid_cycle", first_v, 1);
        chk("done_after_last", done_cyc, last_x + 1);
        if (rdy_mode == 0 && vld_mode == 0) begin
            chk("no_bubbles", last_x - first_x, exp_q.size() - 1);
        end
        if (pat == 0) begin
            chk("upstream_count", ups, w * h);
            chk("ready_in_in_hdr", 32'(rin_early), 0);
        end else begin
            chk("ready_in_pattern", 32'(rin_pat), 0);
        end
        chk("dim_err_in_frame", 32'(dim_seen), 0);
    endtask

    // Refused start: one-cycle dim_err, framer stays idle.
    task automatic dim_try(input int w, input int h);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.width_in = 16'(w); bus.height_in = 16'(h); bus.pattern_sel = 2'd1;
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk($sformatf("dim_err_pulse_%0dx%0d", w, h), 32'(bus.dim_err), 1);
        chk("dim_busy", 32'(bus.busy), 0);
        chk("dim_valid_out", 32'(bus.valid_out), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dim_err_one_cycle", 32'(bus.dim_err), 0);
        chk("dim_busy_after", 32'(bus.busy), 0);
        chk("dim_valid_after", 32'(bus.valid_out), 0);
    endtask

    // Global time bound in case the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, h, pat;
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.width_in = '0; bus.height_in = '0; bus.pattern_sel = '0;
        bus.data_in = '0; bus.valid_in = 1'b0; bus.ready_out = 1'b0;
        next_w = 0; next_h = 0; next_pat = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_valid_out", 32'(bus.valid_out), 0);
        chk("rst_ready_in", 32'(bus.ready_in), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dim_err", 32'(bus.dim_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 4x2 x-ramp, receiver always ready, then receiver toggling
        run_frame(4, 2, 1, 0, 0, 0, 0, -1, -1);
        run_frame(4, 2, 1, 1, 0, 0, 0, -1, -1);

        // 3x1 upstream pixels with a gap every other cycle
        src_q.delete();
        src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
        run_frame(3, 1, 0, 0, 1, 0, 0, -1, -1);

        // Illegal dimensions
        dim_try(0, 5);
        dim_try(c_max_width + 1, 5);
        dim_try(4, 0);

        // 16x16 checker with a start request in the middle of the frame
        run_frame(16, 16, 3, 0, 0, 0, 0, 40, -1);
        chk("checker_8_0", (rx_q.size() > 12) ? 32'(rx_q[12]) : 32'hDEAD, 32'hFF);
        chk("checker_8_8", (rx_q.size() > 140) ? 32'(rx_q[140]) : 32'hDEAD, 32'h00);
        chk("checker_transfers", rx_q.size(), 260);

        // Reset in the middle of a 4x4 frame, then a fresh 2x2 frame
        run_frame(4, 4, 2, 0, 0, 0, 0, -1, 12);
        run_frame(2, 2, 1, 0, 0, 0, 0, -1, -1);

        // Next start accepted in the done cycle
        next_w = 2; next_h = 3; next_pat = 1;
        run_frame(3, 2, 2, 0, 0, 0, 1, -1, -1);
        run_frame(2, 3, 1, 2, 0, 1, 0, -1, -1);

        // Widest legal line
        run_frame(c_max_width, 1, 1, 0, 0, 0, 0, -1, -1);

        // Randomized frames with random stalls on both sides
        for (int k = 0; k < 6; k++) begin
            w   = $urandom_range(20, 1);
            h   = $urandom_range(5, 1);
            pat = $urandom_range(3, 0);
            src_q.delete();
            for (int i = 0; i < w * h; i++) src_q.push_back(8'($urandom));
            run_frame(w, h, pat, 2, 2, 0, 0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_image_stream_framer
`default_nettype wire
